// File: rtl/mmio_controller.sv
// CPU data-bus decoder: main memory pass-through, keyboard event channels and a posted-write FIFO to PRAM.
// Define MMIO_KEY_COUNT_EN to turn each key channel into an 8-bit saturating press counter.
module mmio_controller #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter int                NUM_KEYS   = 6,
  parameter logic [ADDR_W-1:0] KEY_BASE   = 16'h3FF0,
  parameter logic [ADDR_W-1:0] PRAM_ADDR  = 16'h3FFF,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   cpu_data_in,
  input  logic [ADDR_W-1:0]   cpu_data_addr,
  input  logic                cpu_data_wr_en,
  output logic [DATA_W-1:0]   cpu_data_out,
  output logic                cpu_stall,
  input  logic [DATA_W-1:0]   main_data_in,
  output logic [DATA_W-1:0]   main_data_out,
  output logic [ADDR_W-1:0]   main_data_addr,
  output logic                main_data_wr_en,
  input  logic [NUM_KEYS-1:0] key_pulse,
  output logic [DATA_W-1:0]   pram_out,
  output logic                pram_wr_en,
  input  logic                pram_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef MMIO_KEY_COUNT_EN
  localparam int KEY_W = 8;
`else
  localparam int KEY_W = 1;
`endif

  logic                is_pram;
  logic                is_key;
  logic [ADDR_W-1:0]   key_off;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [KEY_W-1:0]    key_state [NUM_KEYS];
  logic [KEY_W-1:0]    key_rd;
  logic [NUM_KEYS-1:0] key_clr;
  logic [15:0]         status;

  // Address decode; anything that is neither PRAM nor a key channel goes to main memory.
  assign key_off = cpu_data_addr - KEY_BASE;
  assign is_pram = (cpu_data_addr == PRAM_ADDR);
  assign is_key  = (cpu_data_addr >= KEY_BASE) && (key_off < ADDR_W'(NUM_KEYS)) && !is_pram;

  assign main_data_out   = cpu_data_in;
  assign main_data_addr  = cpu_data_addr;
  assign main_data_wr_en = cpu_data_wr_en && !is_pram && !is_key;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = cpu_data_wr_en && is_pram && !fifo_full;
  assign pop        = !fifo_empty && !pram_full;
  // Stall is based on the registered count, so a pop in the same cycle does not release it.
  assign cpu_stall  = cpu_data_wr_en && is_pram && fifo_full;

  always_comb begin
    status     = '0;
    status[0]  = pram_full;
    status[1]  = fifo_full;
    status[2]  = fifo_empty;
    status[15:8] = 8'(count);
  end

  always_comb begin
    key_rd  = '0;
    key_clr = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (is_key && (key_off == ADDR_W'(i))) begin
        key_rd     = key_state[i];
        key_clr[i] = cpu_data_wr_en && (cpu_data_in != '0);
      end
    end
  end

  always_comb begin
    if (cpu_data_wr_en)
      cpu_data_out = '0;
    else if (is_pram)
      cpu_data_out = DATA_W'(status);
    else if (is_key)
      cpu_data_out = DATA_W'(key_rd);
    else
      cpu_data_out = main_data_in;
  end

  // FIFO storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= cpu_data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pram_wr_en <= 1'b0;
      pram_out   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pram_out <= fifo_mem[rd_ptr];
      end
      pram_wr_en <= pop;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A pulse wins over a same-cycle clear so no event is lost; with KEY_W=1 this is a sticky latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++)
        key_state[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_pulse[i]) begin
          if (key_clr[i])
            key_state[i] <= KEY_W'(1);
          else if (key_state[i] != {KEY_W{1'b1}})
            key_state[i] <= key_state[i] + 1'b1;
        end else if (key_clr[i]) begin
          key_state[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_controller.sv
// Self-checking bench for mmio_controller: queue/array model checked every cycle plus directed literal checks.
module tb_mmio_controller;

  localparam int          DATA_W     = 16;
  localparam int          ADDR_W     = 16;
  localparam int          NUM_KEYS   = 6;
  localparam logic [15:0] KEY_BASE   = 16'h3FF0;
  localparam logic [15:0] PRAM_ADDR  = 16'h3FFF;
  localparam int          FIFO_DEPTH = 4;
`ifdef MMIO_KEY_COUNT_EN
  localparam int          KMAX       = 255;
`else
  localparam int          KMAX       = 1;
`endif

  logic                clk;
  logic                reset;
  logic [DATA_W-1:0]   cpu_data_in;
  logic [ADDR_W-1:0]   cpu_data_addr;
  logic                cpu_data_wr_en;
  logic [DATA_W-1:0]   cpu_data_out;
  logic                cpu_stall;
  logic [DATA_W-1:0]   main_data_in;
  logic [DATA_W-1:0]   main_data_out;
  logic [ADDR_W-1:0]   main_data_addr;
  logic                main_data_wr_en;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [DATA_W-1:0]   pram_out;
  logic                pram_wr_en;
  logic                pram_full;

  int total = 0;
  int bad   = 0;

  mmio_controller #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_KEYS(NUM_KEYS),
    .KEY_BASE(KEY_BASE), .PRAM_ADDR(PRAM_ADDR), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_data_in(cpu_data_in), .cpu_data_addr(cpu_data_addr), .cpu_data_wr_en(cpu_data_wr_en),
    .cpu_data_out(cpu_data_out), .cpu_stall(cpu_stall),
    .main_data_in(main_data_in), .main_data_out(main_data_out),
    .main_data_addr(main_data_addr), .main_data_wr_en(main_data_wr_en),
    .key_pulse(key_pulse), .pram_out(pram_out), .pram_wr_en(pram_wr_en), .pram_full(pram_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One CPU cycle: inputs change on the falling edge and stay stable across the next rising edge.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                               input logic [NUM_KEYS-1:0] pulse, input logic pf);
    @(negedge clk);
    cpu_data_wr_en = wr;
    cpu_data_addr  = addr;
    cpu_data_in    = data;
    key_pulse      = pulse;
    pram_full      = pf;
    main_data_in   = addr ^ 16'hA5A5;
  endtask

  // Reference model: PRAM FIFO as a queue, key channels as plain integers.
  logic [15:0] model_q[$];
  int          model_keys[NUM_KEYS];
  logic        model_wr_en;
  logic [15:0] model_out;
  int          m_off;
  bit          m_is_key;
  bit          m_is_pram;
  bit          m_full;
  int          m_status;
  int          m_rd;

  task automatic modelReset();
    model_q.delete();
    for (int i = 0; i < NUM_KEYS; i++) model_keys[i] = 0;
    model_wr_en = 1'b0;
    model_out   = 16'h0;
  endtask

  initial begin
    modelReset();
    forever begin
      @(negedge clk);
      #4;
      if (reset) modelReset();
      m_is_pram = (cpu_data_addr == PRAM_ADDR);
      m_off     = int'(cpu_data_addr) - int'(KEY_BASE);
      m_is_key  = !m_is_pram && (m_off >= 0) && (m_off < NUM_KEYS);
      m_full    = (model_q.size() == FIFO_DEPTH);
      m_status  = (pram_full ? 1 : 0) + (m_full ? 2 : 0) + ((model_q.size() == 0) ? 4 : 0)
                + (model_q.size() << 8);
      if (cpu_data_wr_en)  m_rd = 0;
      else if (m_is_pram)  m_rd = m_status;
      else if (m_is_key)   m_rd = model_keys[m_off];
      else                 m_rd = int'(main_data_in);
      checkOutput("model main_data_out", main_data_out, cpu_data_in);
      checkOutput("model main_data_addr", main_data_addr, cpu_data_addr);
      checkOutput("model main_data_wr_en", main_data_wr_en, cpu_data_wr_en && !m_is_pram && !m_is_key);
      checkOutput("model cpu_stall", cpu_stall, cpu_data_wr_en && m_is_pram && m_full);
      checkOutput("model cpu_data_out", cpu_data_out, m_rd);
      checkOutput("model pram_wr_en", pram_wr_en, model_wr_en);
      checkOutput("model pram_out", pram_out, model_out);
      @(posedge clk);
      if (reset) begin
        modelReset();
      end else begin
        if (model_q.size() > 0 && !pram_full) begin
          model_out   = model_q.pop_front();
          model_wr_en = 1'b1;
        end else begin
          model_wr_en = 1'b0;
        end
        if (cpu_data_wr_en && m_is_pram && !m_full) model_q.push_back(cpu_data_in);
        for (int i = 0; i < NUM_KEYS; i++) begin
          bit clr;
          clr = cpu_data_wr_en && m_is_key && (m_off == i) && (cpu_data_in != 0);
          if (key_pulse[i] && clr)  model_keys[i] = 1;
          else if (key_pulse[i])    model_keys[i] = (model_keys[i] + 1 > KMAX) ? KMAX : model_keys[i] + 1;
          else if (clr)             model_keys[i] = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0; cpu_data_in = '0; cpu_data_addr = '0; cpu_data_wr_en = 1'b0;
    key_pulse = '0; pram_full = 1'b0; main_data_in = '0;
    #1 reset = 1'b1;
    #2;
    checkOutput("reset pram_wr_en", pram_wr_en, 0);
    checkOutput("reset pram_out", pram_out, 0);
    checkOutput("reset cpu_stall", cpu_stall, 0);
    cpu_data_addr = PRAM_ADDR;
    #1;
    checkOutput("reset status", cpu_data_out, 32'h0004);
    @(negedge clk);
    reset = 1'b0;

    // Two posted writes drain one cycle after each push.
    applyStimulus(1, PRAM_ADDR, 16'h00AA, '0, 0); #4;
    checkOutput("pram write main we", main_data_wr_en, 0);
    applyStimulus(1, PRAM_ADDR, 16'h00BB, '0, 0); #4;
    checkOutput("drain latency idle", pram_wr_en, 0);
    applyStimulus(0, 16'h0100, 16'h0, '0, 0); #4;
    checkOutput("drain AA we", pram_wr_en, 1);
    checkOutput("drain AA data", pram_out, 32'h00AA);
    applyStimulus(0, 16'h0100, 16'h0, '0, 0); #4;
    checkOutput("drain BB we", pram_wr_en, 1);
    checkOutput("drain BB data", pram_out, 32'h00BB);
    applyStimulus(0, 16'h0100, 16'h0, '0, 0); #4;
    checkOutput("drain done we", pram_wr_en, 0);
    checkOutput("drain done hold", pram_out, 32'h00BB);

    applyStimulus(1, 16'h0100, 16'h5555, '0, 0); #4;
    checkOutput("main write we", main_data_wr_en, 1);
    checkOutput("main write pram we", pram_wr_en, 0);

    // Fill the FIFO while PRAM reports full; the fifth write must stall.
    for (int v = 1; v <= 5; v++) begin
      applyStimulus(1, PRAM_ADDR, 16'(v), '0, 1); #4;
      checkOutput("fill stall", cpu_stall, (v == 5) ? 1 : 0);
    end
    applyStimulus(0, PRAM_ADDR, 16'h0, '0, 0); #4;
    checkOutput("full status", cpu_data_out, 32'h0402);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 16'h0100, 16'h0, '0, 0); #4;
      checkOutput("ordered drain we", pram_wr_en, 1);
      checkOutput("ordered drain data", pram_out, k);
    end
    applyStimulus(0, 16'h0100, 16'h0, '0, 0); #4;
    checkOutput("ordered drain end", pram_wr_en, 0);

    // Sticky key channel 2.
    applyStimulus(0, 16'h0100, 16'h0, 6'b000100, 0);
    applyStimulus(0, KEY_BASE + 16'd2, 16'h0, '0, 0); #4;
    checkOutput("key2 after pulse", cpu_data_out, 1);
    applyStimulus(1, KEY_BASE + 16'd2, 16'h0001, '0, 0); #4;
    checkOutput("key2 clear main we", main_data_wr_en, 0);
    applyStimulus(0, KEY_BASE + 16'd2, 16'h0, '0, 0); #4;
    checkOutput("key2 after clear", cpu_data_out, 0);
    applyStimulus(0, 16'h0100, 16'h0, 6'b000100, 0);
    applyStimulus(1, KEY_BASE + 16'd2, 16'h0000, '0, 0);
    applyStimulus(0, KEY_BASE + 16'd2, 16'h0, '0, 0); #4;
    checkOutput("key2 zero write", cpu_data_out, 1);

    // Pulse and clear together keep the event; then saturate channel 0.
    applyStimulus(1, KEY_BASE, 16'h0001, 6'b000001, 0);
    applyStimulus(0, KEY_BASE, 16'h0, '0, 0); #4;
    checkOutput("key0 pulse+clear", cpu_data_out, 1);
    for (int n = 0; n < 300; n++)
      applyStimulus(0, KEY_BASE + 16'd1, 16'h0, 6'b000001, 0);
    applyStimulus(0, KEY_BASE, 16'h0, '0, 0); #4;
    checkOutput("key0 saturate", cpu_data_out, KMAX);

    // Addresses past the last key channel are main memory.
    applyStimulus(1, 16'h3FF6, 16'h1234, '0, 0); #4;
    checkOutput("gap write main we", main_data_wr_en, 1);
    applyStimulus(0, 16'h3FF6, 16'h0, '0, 0); #4;
    checkOutput("gap read 3FF6", cpu_data_out, 32'h9A53);
    applyStimulus(0, 16'h3FFE, 16'h0, '0, 0); #4;
    checkOutput("gap read 3FFE", cpu_data_out, 32'h9A5B);

    // Reset while draining discards the queue.
    applyStimulus(1, PRAM_ADDR, 16'h0011, '0, 1);
    applyStimulus(1, PRAM_ADDR, 16'h0022, '0, 1);
    applyStimulus(1, PRAM_ADDR, 16'h0033, '0, 1);
    applyStimulus(0, 16'h0100, 16'h0, '0, 0);
    @(negedge clk);
    reset = 1'b1;
    #4;
    checkOutput("reset mid-drain we", pram_wr_en, 0);
    checkOutput("reset mid-drain out", pram_out, 0);
    @(negedge clk);
    reset = 1'b0;
    cpu_data_wr_en = 1'b0;
    cpu_data_addr  = PRAM_ADDR;
    #4;
    checkOutput("post-reset status", cpu_data_out, 32'h0004);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(0, 16'h0100, 16'h0, '0, 0); #4;
      checkOutput("post-reset no drain", pram_wr_en, 0);
    end

    @(negedge clk);
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_controller.md
MMIO_CONTROLLER -- requirements
Module: mmio_controller

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning data width of CPU, main memory and PRAM paths.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning CPU data address width.
REQ-003 The block SHALL have parameter NUM_KEYS, default 6, range 1..8, meaning number of keyboard event channels.
REQ-004 The block SHALL have parameter KEY_BASE, default 16'h3FF0, meaning address of key channel 0, with channel i at KEY_BASE+i.
REQ-005 The block SHALL have parameter PRAM_ADDR, default 16'h3FFF, meaning PRAM write-data and status address.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4, power of 2 in the range 2..16, meaning PRAM posted-write buffer depth.
REQ-007 The block SHALL have ports: clk in 1 system clock; reset in 1 asynchronous active-high reset; one clock, with reset asynchronous and active-high.
REQ-008 The block SHALL have ports: cpu_data_in in DATA_W; cpu_data_addr in ADDR_W; cpu_data_wr_en in 1; cpu_data_out out DATA_W read data; cpu_stall out 1 CPU must hold its request.
REQ-009 The block SHALL have ports: main_data_in in DATA_W; main_data_out out DATA_W; main_data_addr out ADDR_W; main_data_wr_en out 1.
REQ-010 The block SHALL have ports: key_pulse in NUM_KEYS, one-cycle key event per channel; pram_out out DATA_W; pram_wr_en out 1; pram_full in 1, PRAM queue full.

Function
REQ-011 The block SHALL drive main_data_out=cpu_data_in and main_data_addr=cpu_data_addr combinationally at all times.
REQ-012 The block SHALL assert main_data_wr_en=cpu_data_wr_en only when cpu_data_addr is neither PRAM_ADDR nor a key address; all other accesses are main-memory accesses.
REQ-013 cpu_data_out SHALL be combinational: main_data_in for main accesses, key state for key addresses, status word for PRAM_ADDR reads, 0 during any write.
REQ-014 A CPU write to PRAM_ADDR SHALL push cpu_data_in into the FIFO on the clock edge when the FIFO is not full.
REQ-015 cpu_stall SHALL be asserted combinationally iff cpu_data_wr_en=1, addr=PRAM_ADDR and the FIFO is full; no push occurs that cycle, and a same-cycle pop does not release the stall.
REQ-016 When the FIFO is non-empty and pram_full=0, the block SHALL pop the head and register pram_out=head, pram_wr_en=1 for exactly one cycle; otherwise pram_wr_en=0 and pram_out holds.
REQ-017 Drain latency SHALL be 1 cycle: a push into an empty FIFO with pram_full=0 appears on pram_wr_en on the following edge.
REQ-018 Simultaneous push and pop on a non-full FIFO SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be strictly FIFO.
REQ-019 The PRAM status word SHALL be: bit0 pram_full, bit1 fifo_full, bit2 fifo_empty, bits[15:8] occupancy count, with all other bits 0.
REQ-020 A key_pulse[i]=1 SHALL set key latch i; a CPU write of nonzero data to KEY_BASE+i SHALL clear it; a write of zero SHALL have no effect.
REQ-021 A simultaneous pulse and clear on the same channel SHALL leave the latch set, so that no event is lost.
REQ-022 A key read SHALL return the zero-extended latch value, with no side effect.
REQ-023 Addresses KEY_BASE+NUM_KEYS..PRAM_ADDR-1 SHALL be treated as main memory.

Reset
REQ-024 Asserting reset SHALL immediately clear the FIFO pointers and count, all key latches and counters, pram_wr_en and pram_out.
REQ-025 Reset mid-drain SHALL discard all queued entries, and pram_wr_en SHALL be 0 from reset assertion onward.
REQ-026 Combinational outputs SHALL follow REQ-011..REQ-015 with reset state, so cpu_stall=0 while reset is asserted.

Configuration
REQ-027 With macro MMIO_KEY_COUNT_EN defined, each key channel SHALL be an 8-bit saturating press counter: a pulse increments it, saturating at 255, a read returns the count, and a nonzero write clears it.
REQ-028 With MMIO_KEY_COUNT_EN defined, a simultaneous pulse and clear SHALL load the counter to 1.
REQ-029 Without MMIO_KEY_COUNT_EN, each channel SHALL be the 1-bit sticky latch of REQ-020..REQ-022.

Verification
REQ-030 The bench SHALL cover: write 16'h00AA, 16'h00BB to PRAM_ADDR with pram_full=0 -> pram_wr_en pulses on the next edges with pram_out AA then BB.
REQ-031 The bench SHALL cover: pram_full=1 and 5 writes with depth 4 -> first 4 accepted, 5th raises cpu_stall, status read 16'h0402; releasing pram_full drains all 4 in order.
REQ-032 The bench SHALL cover: key_pulse[2] once -> read KEY_BASE+2 returns 1; write 16'h0001 -> reads 0; write 16'h0000 after a new pulse -> still 1.
REQ-033 The bench SHALL cover: key_pulse[0] in the same cycle as a clear write -> latch is 1 (or the count is 1 with MMIO_KEY_COUNT_EN); 300 pulses -> count 255.
REQ-034 The bench SHALL cover: write to 16'h0100 -> main_data_wr_en=1 with pram_wr_en=0; a write to PRAM_ADDR -> main_data_wr_en=0.
REQ-035 The bench SHALL cover: reset asserted with 3 entries queued -> pram_wr_en=0 immediately and status reads 16'h0004 after release.
